// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and width helpers for the memory bus arbiter and its picker.
// The interrupt controller imports this package as well.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // A grant id is always at least one bit wide, even for a single channel.
    function automatic int gid_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

    function automatic int cnt_w(input int timeout);
        return (timeout <= 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int AW   = 16,
    parameter int DW   = 128
);
    localparam int GW = gid_w(N_CH);

    logic [N_CH-1:0]    REQ_EN;
    logic [N_CH-1:0]    REQ_WR;
    logic [N_CH*AW-1:0] REQ_A;
    logic [N_CH*DW-1:0] REQ_WDATA;
    logic [DW-1:0]      REQ_RDATA;
    logic [N_CH-1:0]    REQ_R;
    logic [N_CH-1:0]    REQ_ERR;
    logic               MEM_EN;
    logic               MEM_WR;
    logic [AW-1:0]      MEM_A;
    logic [DW-1:0]      MEM_WDATA;
    logic [DW-1:0]      MEM_RDATA;
    logic               MEM_R;
    logic [GW-1:0]      GRANT_ID;

    modport master (
        input  REQ_EN, REQ_WR, REQ_A, REQ_WDATA, MEM_RDATA, MEM_R,
        output REQ_RDATA, REQ_R, REQ_ERR, MEM_EN, MEM_WR, MEM_A, MEM_WDATA, GRANT_ID
    );

    modport slave (
        output REQ_EN, REQ_WR, REQ_A, REQ_WDATA, MEM_RDATA, MEM_R,
        input  REQ_RDATA, REQ_R, REQ_ERR, MEM_EN, MEM_WR, MEM_A, MEM_WDATA, GRANT_ID
    );

endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational request picker: round-robin search from a rotating base,
// or lowest-index-wins when mode is 0.
module arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N_CH = 3,
    localparam int IW  = gid_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   base,
    input  logic            mode,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan from the far end so the last hit is the nearest one to the start.
        for (int k = N_CH - 1; k >= 0; k--) begin
            int j;
            if (mode) begin
                j = int'(base) + k;
                if (j >= N_CH) j = j - N_CH;
            end else begin
                j = k;
            end
            if (req[j]) idx = IW'(j);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-channel arbiter onto a single memory port: one outstanding transaction,
// fixed or round-robin grant, optional watchdog that completes with an error.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int AW      = 16,
    parameter int DW      = 128,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    mem_bus_arbiter_if.master bus
);

    localparam int GW = gid_w(N_CH);
    localparam int CW = cnt_w(TIMEOUT);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   a_q, a_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            mem_en_q, mem_en_d;
    logic [N_CH-1:0] req_r_q, req_r_d;
    logic [N_CH-1:0] req_err_q, req_err_d;

    logic [GW-1:0]   base;
    logic            pick_vld;
    logic [GW-1:0]   pick_idx;

    assign base = (int'(last_q) == N_CH - 1) ? '0 : last_q + 1'b1;

    arb_rr_pick #(.N_CH(N_CH)) u_pick (
        .req   (bus.REQ_EN),
        .base  (base),
        .mode  (RR_MODE != 0),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        a_d       = a_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_en_d  = 1'b0;
        req_r_d   = '0;
        req_err_d = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d  = BUSY;
                    gid_d    = pick_idx;
                    if (RR_MODE != 0) last_d = pick_idx;
                    cnt_d    = '0;
                    wr_d     = bus.REQ_WR[int'(pick_idx)];
                    a_d      = bus.REQ_A[int'(pick_idx)*AW +: AW];
                    wdata_d  = bus.REQ_WDATA[int'(pick_idx)*DW +: DW];
                    mem_en_d = 1'b1;
                end
            end
            BUSY: begin
                cnt_d    = cnt_q + 1'b1;
                mem_en_d = 1'b1;
                // A completion in the last allowed cycle beats the watchdog.
                if (bus.MEM_R) begin
                    rdata_d              = bus.MEM_RDATA;
                    state_d              = DONE;
                    mem_en_d             = 1'b0;
                    req_r_d[int'(gid_q)] = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d                = '0;
                    state_d                = DONE;
                    mem_en_d               = 1'b0;
                    req_r_d[int'(gid_q)]   = 1'b1;
                    req_err_d[int'(gid_q)] = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            gid_q     <= '0;
            last_q    <= GW'(N_CH - 1);
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            a_q       <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mem_en_q  <= 1'b0;
            req_r_q   <= '0;
            req_err_q <= '0;
        end else begin
            state_q   <= state_d;
            gid_q     <= gid_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            a_q       <= a_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_en_q  <= mem_en_d;
            req_r_q   <= req_r_d;
            req_err_q <= req_err_d;
        end
    end

    assign bus.MEM_EN    = mem_en_q;
    assign bus.MEM_WR    = wr_q;
    assign bus.MEM_A     = a_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.REQ_RDATA = rdata_q;
    assign bus.REQ_R     = req_r_q;
    assign bus.REQ_ERR   = req_err_q;
    assign bus.GRANT_ID  = gid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance with an 8-cycle watchdog,
// plus a fixed-priority twin that shadows it during the arbitration scenario.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int TO = 8;
    localparam int GW = gid_w(N);

    typedef struct {
        int            ch;
        logic [DW-1:0] rdata;
        logic          err;
        bit            chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic fixed_en;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.N_CH(N), .AW(AW), .DW(DW)) ifa ();
    mem_bus_arbiter_if #(.N_CH(N), .AW(AW), .DW(DW)) ifb ();

    mem_bus_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(TO)) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa.master));
    mem_bus_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(TO)) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb.master));

    assign ifb.REQ_EN    = fixed_en ? ifa.REQ_EN : '0;
    assign ifb.REQ_WR    = ifa.REQ_WR;
    assign ifb.REQ_A     = ifa.REQ_A;
    assign ifb.REQ_WDATA = ifa.REQ_WDATA;
    assign ifb.MEM_R     = ifa.MEM_R;
    assign ifb.MEM_RDATA = ifa.MEM_RDATA;

    // Memory responder and completion monitor for instance A; returns what it saw.
    task automatic run_txn(input int respond_at, input logic [DW-1:0] rd, input int budget,
                           output int busy, output bit done, output logic [N-1:0] r,
                           output logic [N-1:0] e, output logic [DW-1:0] rdata,
                           output logic [GW-1:0] ga, output logic [GW-1:0] gb,
                           output logic wr0, output logic [AW-1:0] a0,
                           output logic [DW-1:0] wd0, output bit stable, output logic men_done);
        busy = 0; done = 0; stable = 1; r = '0; e = '0; rdata = '0; ga = '0; gb = '0;
        wr0 = 1'b0; a0 = '0; wd0 = '0; men_done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (ifa.REQ_R != '0) begin
                done = 1; r = ifa.REQ_R; e = ifa.REQ_ERR; rdata = ifa.REQ_RDATA;
                men_done = ifa.MEM_EN;
                ifa.MEM_R = 1'b0;
            end else if (ifa.MEM_EN) begin
                busy++;
                if (busy == 1) begin
                    ga = ifa.GRANT_ID; gb = ifb.GRANT_ID; wr0 = ifa.MEM_WR;
                    a0 = ifa.MEM_A; wd0 = ifa.MEM_WDATA;
                end else if (ifa.MEM_WR !== wr0 || ifa.MEM_A !== a0 || ifa.MEM_WDATA !== wd0) begin
                    stable = 0;
                end
                ifa.MEM_R     = (respond_at != 0 && busy == respond_at);
                ifa.MEM_RDATA = ifa.MEM_R ? rd : {4{$urandom}};
            end else begin
                ifa.MEM_R = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ifa.MEM_EN !== 1'b0 || ifa.REQ_R !== '0 || ifa.REQ_ERR !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got en=%b r=%b err=%b, want 0/000/000",
                     ifa.MEM_EN, ifa.REQ_R, ifa.REQ_ERR);
        end
        n_cmp++;
        if (ifa.GRANT_ID !== '0 || ifa.MEM_WR !== 1'b0 || ifa.MEM_A !== '0) begin
            n_bad++;
            $display("FAIL reset_addr: got gid=%0d wr=%b a=%h, want 0/0/0",
                     ifa.GRANT_ID, ifa.MEM_WR, ifa.MEM_A);
        end
        n_cmp++;
        if (ifa.REQ_RDATA !== '0 || ifa.MEM_WDATA !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got rdata=%h wdata=%h, want 0", ifa.REQ_RDATA, ifa.MEM_WDATA);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_g[4] = '{0, 1, 2, 0};
        int busy; bit done, stable; logic [N-1:0] r, e, exp_r; logic [DW-1:0] rdata, wd0, rd;
        logic [GW-1:0] ga, gb; logic wr0, mdone; logic [AW-1:0] a0; exp_t x;
        do_reset();
        for (int i = 0; i < N; i++) ifa.REQ_A[i*AW +: AW] = AW'(16'h0100 * i);
        ifa.REQ_WR = '0;
        ifa.REQ_EN = 3'b111;
        fixed_en   = 1'b1;
        for (int t = 0; t < 4; t++) begin
            rd = {4{$urandom}};
            sb.push_back('{exp_g[t], rd, 1'b0, 1'b1});
            run_txn(1, rd, 10, busy, done, r, e, rdata, ga, gb, wr0, a0, wd0, stable, mdone);
            n_cmp++;
            if (!done) begin
                n_bad++; $display("FAIL rr_done[%0d]: no REQ_R within 10 cycles", t);
                void'(sb.pop_front());
                continue;
            end
            x = sb.pop_front();
            exp_r = '0; exp_r[x.ch] = 1'b1;
            n_cmp++;
            if (ga !== GW'(x.ch) || r !== exp_r || e !== '0) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got gid=%0d r=%b err=%b, want gid=%0d r=%b err=000",
                         t, ga, r, e, x.ch, exp_r);
            end
            n_cmp++;
            if (rdata !== x.rdata || busy != 1 || a0 !== AW'(16'h0100 * x.ch)) begin
                n_bad++;
                $display("FAIL rr_data[%0d]: got rdata=%h busy=%0d a=%h, want %h/1/%h",
                         t, rdata, busy, a0, x.rdata, AW'(16'h0100 * x.ch));
            end
            n_cmp++;
            if (gb !== '0) begin
                n_bad++; $display("FAIL fixed_grant[%0d]: got gid=%0d, want 0", t, gb);
            end
        end
        ifa.REQ_EN = '0;
        fixed_en   = 1'b0;
    endtask

    task automatic test_read();
        int busy; bit done, stable; logic [N-1:0] r, e, exp_r; logic [DW-1:0] rdata, wd0;
        logic [GW-1:0] ga, gb; logic wr0, mdone; logic [AW-1:0] a0; exp_t x;
        @(negedge clk);
        ifa.REQ_EN = 3'b010; ifa.REQ_WR = '0; ifa.REQ_A[AW +: AW] = 16'h0040;
        sb.push_back('{1, 128'hDEAD_BEEF, 1'b0, 1'b1});
        run_txn(3, 128'hDEAD_BEEF, 20, busy, done, r, e, rdata, ga, gb, wr0, a0, wd0, stable, mdone);
        ifa.REQ_EN = '0;
        x = sb.pop_front();
        exp_r = '0; exp_r[x.ch] = 1'b1;
        n_cmp++;
        if (!done || busy != 3 || a0 !== 16'h0040 || wr0 !== 1'b0 || !stable || ga !== GW'(1)) begin
            n_bad++;
            $display("FAIL read_bus: got done=%0d busy=%0d a=%h wr=%b stable=%0d gid=%0d, want 1/3/0040/0/1/1",
                     done, busy, a0, wr0, stable, ga);
        end
        n_cmp++;
        if (r !== exp_r || e !== '0 || rdata !== x.rdata || mdone !== 1'b0) begin
            n_bad++;
            $display("FAIL read_done: got r=%b err=%b rdata=%h en=%b, want r=%b err=000 rdata=%h en=0",
                     r, e, rdata, mdone, exp_r, x.rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (ifa.REQ_R !== '0 || ifa.REQ_RDATA !== x.rdata) begin
            n_bad++;
            $display("FAIL read_pulse: got r=%b rdata=%h after completion, want 000/%h",
                     ifa.REQ_R, ifa.REQ_RDATA, x.rdata);
        end
    endtask

    task automatic test_write();
        int busy; bit done, stable; logic [N-1:0] r, e; logic [DW-1:0] rdata, wd0;
        logic [GW-1:0] ga, gb; logic wr0, mdone; logic [AW-1:0] a0; exp_t x;
        @(negedge clk);
        ifa.REQ_EN = 3'b001; ifa.REQ_WR = 3'b001; ifa.REQ_A[0 +: AW] = 16'h1000;
        ifa.REQ_WDATA[0 +: DW] = {16{8'hA5}};
        sb.push_back('{0, '0, 1'b0, 1'b0});
        run_txn(2, {4{$urandom}}, 20, busy, done, r, e, rdata, ga, gb, wr0, a0, wd0, stable, mdone);
        ifa.REQ_EN = '0; ifa.REQ_WR = '0;
        x = sb.pop_front();
        n_cmp++;
        if (!done || wr0 !== 1'b1 || a0 !== 16'h1000 || wd0 !== {16{8'hA5}} || !stable || busy != 2) begin
            n_bad++;
            $display("FAIL write_bus: got done=%0d wr=%b a=%h wdata=%h stable=%0d busy=%0d",
                     done, wr0, a0, wd0, stable, busy);
        end
        n_cmp++;
        if (r !== 3'b001 || e !== '0 || ga !== GW'(x.ch)) begin
            n_bad++;
            $display("FAIL write_done: got r=%b err=%b gid=%0d, want 001/000/%0d", r, e, ga, x.ch);
        end
    endtask

    task automatic test_timeout();
        int busy; bit done, stable; logic [N-1:0] r, e, exp_r; logic [DW-1:0] rdata, wd0;
        logic [GW-1:0] ga, gb; logic wr0, mdone; logic [AW-1:0] a0; exp_t x;
        @(negedge clk);
        ifa.REQ_EN = 3'b100; ifa.REQ_A[2*AW +: AW] = 16'h0200;
        sb.push_back('{2, '0, 1'b1, 1'b1});
        run_txn(0, '0, 30, busy, done, r, e, rdata, ga, gb, wr0, a0, wd0, stable, mdone);
        ifa.REQ_EN = '0;
        x = sb.pop_front();
        exp_r = '0; exp_r[x.ch] = 1'b1;
        n_cmp++;
        if (!done || busy != TO) begin
            n_bad++; $display("FAIL timeout_len: got done=%0d busy=%0d, want 1/%0d", done, busy, TO);
        end
        n_cmp++;
        if (r !== exp_r || e !== exp_r || rdata !== x.rdata) begin
            n_bad++;
            $display("FAIL timeout_err: got r=%b err=%b rdata=%h, want %b/%b/0", r, e, rdata, exp_r, exp_r);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ifa.MEM_EN !== 1'b0 || ifa.REQ_R !== '0 || ifa.REQ_ERR !== '0) begin
            n_bad++;
            $display("FAIL timeout_idle: got en=%b r=%b err=%b, want 0/000/000",
                     ifa.MEM_EN, ifa.REQ_R, ifa.REQ_ERR);
        end
    endtask

    task automatic test_race();
        int busy; bit done, stable; logic [N-1:0] r, e, exp_r; logic [DW-1:0] rdata, wd0, rd;
        logic [GW-1:0] ga, gb; logic wr0, mdone; logic [AW-1:0] a0; exp_t x;
        @(negedge clk);
        rd = {4{$urandom}};
        ifa.REQ_EN = 3'b010; ifa.REQ_A[AW +: AW] = 16'h0777;
        sb.push_back('{1, rd, 1'b0, 1'b1});
        run_txn(TO, rd, 30, busy, done, r, e, rdata, ga, gb, wr0, a0, wd0, stable, mdone);
        ifa.REQ_EN = '0;
        x = sb.pop_front();
        exp_r = '0; exp_r[x.ch] = 1'b1;
        n_cmp++;
        if (!done || busy != TO || r !== exp_r || e !== '0 || rdata !== x.rdata) begin
            n_bad++;
            $display("FAIL race: got done=%0d busy=%0d r=%b err=%b rdata=%h, want 1/%0d/%b/000/%h",
                     done, busy, r, e, rdata, TO, exp_r, x.rdata);
        end
    endtask

    task automatic test_reset_mid_busy();
        int busy; bit done, stable, seen_r; logic [N-1:0] r, e; logic [DW-1:0] rdata, wd0, rd;
        logic [GW-1:0] ga, gb; logic wr0, mdone; logic [AW-1:0] a0; exp_t x;
        @(negedge clk);
        ifa.REQ_EN = 3'b010;
        busy = 0;
        for (int c = 0; c < 10 && busy < 2; c++) begin
            @(negedge clk);
            if (ifa.MEM_EN) busy++;
        end
        n_cmp++;
        if (busy != 2) begin
            n_bad++; $display("FAIL rst_busy_reach: got busy=%0d, want 2", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (ifa.MEM_EN !== 1'b0 || ifa.REQ_R !== '0) begin
            n_bad++;
            $display("FAIL rst_async: got en=%b r=%b right after reset, want 0/000", ifa.MEM_EN, ifa.REQ_R);
        end
        ifa.REQ_EN = 3'b111;
        seen_r = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifa.REQ_R !== '0 || ifa.REQ_ERR !== '0) seen_r = 1;
        end
        rst = 1'b0;
        n_cmp++;
        if (seen_r) begin
            n_bad++; $display("FAIL rst_no_pulse: got a completion pulse during reset, want none");
        end
        rd = {4{$urandom}};
        sb.push_back('{0, rd, 1'b0, 1'b1});
        run_txn(1, rd, 10, busy, done, r, e, rdata, ga, gb, wr0, a0, wd0, stable, mdone);
        ifa.REQ_EN = '0;
        x = sb.pop_front();
        n_cmp++;
        if (!done || ga !== GW'(x.ch) || r !== 3'b001 || rdata !== x.rdata) begin
            n_bad++;
            $display("FAIL rst_first_grant: got done=%0d gid=%0d r=%b rdata=%h, want 1/0/001/%h",
                     done, ga, r, rdata, x.rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        fixed_en = 1'b0;
        ifa.REQ_EN = '0; ifa.REQ_WR = '0; ifa.REQ_A = '0; ifa.REQ_WDATA = '0;
        ifa.MEM_R = 1'b0; ifa.MEM_RDATA = '0;
        test_reset();
        test_round_robin();
        test_read();
        test_write();
        test_timeout();
        test_race();
        test_reset_mid_busy();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
